// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage of the 5-stage core. It sits at the consumer end of the EX/MEM
// pipeline buffer and does the following:
//   * Passes non-memory ops straight through to the MEM/WB register, with one
//     cycle of latency.
//   * For loads and stores, latches the operation and runs a req/ack
//     transaction to data memory. The upstream pipeline is stalled until the
//     transaction completes or times out.
//   * Presents the completed result to MEM/WB for exactly one cycle (DONE).
//     After that cycle the outputs return to a bubble.
//
// Parameters
//   ADDR_W   data-memory address width (dmem_addr = ALUResult_i[ADDR_W-1:0])
//   TIMEOUT  cycles spent in ACCESS without dmem_ack before the access is
//            aborted (must be >= 2)
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   MemRead_i / MemWrite_i       load / store request from EX/MEM
//   MemtoReg_i, ALUResult_i      writeback select, address or ALU result
//   MemData_i, rd_i              store data, destination register
//   dmem_req/we/addr/wdata       request side of the data-memory port
//   dmem_rdata/ack               response side (ack is a one-cycle pulse)
//   stall_o                      hold PC, IF/ID, ID/EX, EX/MEM this cycle
//   mem_err_o                    sticky: timeout or read+write conflict
//   MemtoReg_o, ReadData_o,
//   ALUResult_o, rd_o            values for the MEM/WB register
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic [31:0]       ALUResult_i,
  input  logic [31:0]       MemData_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_o,
  output logic              mem_err_o,
  output logic              MemtoReg_o,
  output logic [31:0]       ReadData_o,
  output logic [31:0]       ALUResult_o,
  output logic [4:0]        rd_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // The operation captured on acceptance. The EX/MEM buffer is held by the
  // stall, but the MEM/WB values are taken from this copy so that they never
  // depend on upstream behaviour during the access.
  logic             lat_mtr;
  logic [31:0]      lat_alu;
  logic [4:0]       lat_rd;

  logic             mem_op;
  assign mem_op = MemRead_i | MemWrite_i;

  // During ACCESS the stall is the registered request. In IDLE the stall is
  // raised combinationally as soon as a memory op appears. That lets the
  // upstream stages freeze in the same cycle the op is accepted. The stall is
  // gated by rst so that it also drops while reset is held, even if the buffer
  // still shows a memory op.
  assign stall_o = rst & (dmem_req | ((state == IDLE) & mem_op));

  // NOTE: every register here, the datapath latches included, sits on the
  // async reset. Reset therefore returns all outputs to zero immediately, and
  // an in-flight request is abandoned within the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      lat_mtr     <= 1'b0;
      lat_alu     <= '0;
      lat_rd      <= '0;
      mem_err_o   <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      rd_o        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. All the state in this block
      // updates together at the edge, and every decision reads the
      // pre-edge values.
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Accept. A read+write conflict is executed as a store and
            // flagged as an error.
            dmem_req    <= 1'b1;
            dmem_we     <= MemWrite_i;
            dmem_addr   <= ALUResult_i[ADDR_W-1:0];
            dmem_wdata  <= MemData_i;
            lat_mtr     <= MemtoReg_i;
            lat_alu     <= ALUResult_i;
            lat_rd      <= rd_i;
            wait_cnt    <= '0;
            if (MemRead_i & MemWrite_i) begin
              mem_err_o <= 1'b1;
            end
            MemtoReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            rd_o        <= '0;
            state       <= ACCESS;
          end else begin
            // Non-memory op: pass through.
            MemtoReg_o  <= MemtoReg_i;
            ReadData_o  <= '0;
            ALUResult_o <= ALUResult_i;
            rd_o        <= rd_i;
          end
        end

        ACCESS: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            ReadData_o  <= dmem_we ? 32'd0 : dmem_rdata;
            MemtoReg_o  <= lat_mtr;
            ALUResult_o <= lat_alu;
            rd_o        <= lat_rd;
            state       <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            // Abort. With rd forced to 0 the writeback is harmless, which
            // effectively drops the result.
            dmem_req    <= 1'b0;
            mem_err_o   <= 1'b1;
            ReadData_o  <= '0;
            MemtoReg_o  <= lat_mtr;
            ALUResult_o <= lat_alu;
            rd_o        <= '0;
            state       <= DONE;
          end else begin
            wait_cnt    <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // Upstream advances at this edge. The buffer still holds the op
          // that just completed, so the inputs are ignored for one cycle.
          MemtoReg_o  <= 1'b0;
          ReadData_o  <= '0;
          ALUResult_o <= '0;
          rd_o        <= '0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
